bp_ltb_perf_counters: RTL and testbench
=======================================

Name: bp_ltb_perf_counters

Overview:
Synthesizable, parametrised successor to the LTB trace profiler: on-chip saturating event counters and an exit trip-count histogram for the loop termination buffer, instead of host-side trace files. Supports multiple LTB lookup ports and a registered counter readout port for a CSR/debug bridge. Sits beside the LTB in the front end and snoops its lookup and update handshakes.

Parameters:
vaddr_width_p, 39, virtual address width (only used for the optional address filter)
ltb_cnt_width_p, 8, width of LTB trip/spec counters
rd_ports_p, 2, number of LTB lookup ports observed
ctr_width_p, 32, width of each event counter
hist_bins_p, 8, number of trip-count histogram bins (power of 2, >=2)
hist_shift_p, 0, right shift applied to trip count before binning

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
en_i  in  1  counting enable; 0 freezes all counters
clear_i  in  1  synchronous clear of all counters and sat_o
r_v_i  in  rd_ports_p  lookup issued on port p this cycle
pred_v_i  in  rd_ports_p  LTB hit for the lookup issued the previous cycle
pred_conf_i  in  rd_ports_p  prediction confident
pred_taken_i  in  rd_ports_p  prediction taken
w_v_i  in  1  update request valid
w_yumi_i  in  1  LTB accepted update
br_mispredict_i  in  1  update is for a mispredicted branch
br_conf_i  in  1  entry was confident
br_taken_i  in  1  branch resolved taken (0 = loop exit)
br_trip_cnt_i  in  ltb_cnt_width_p  resolved trip count
rd_v_i  in  1  counter read request
rd_addr_i  in  `BSG_SAFE_CLOG2(4*rd_ports_p+4+hist_bins_p)  counter index
rd_v_o  out  1  read data valid
rd_data_o  out  ctr_width_p  counter value
sat_o  out  1  sticky: some counter saturated

Behaviour:
- Clock clk_i; reset_i synchronous, active-high. Reset: all counters 0, r_v_r 0, rd_v_o 0, rd_data_o 0, sat_o 0.
- Per-port pending flag r_v_r[p] <= r_v_i[p] every cycle (unaffected by en_i). pred_*_i[p] sampled only when r_v_r[p]=1; ignored otherwise.
- Counter map, port p (base 4p): +0 lookups (r_v_i[p]), +1 hits (r_v_r & pred_v), +2 confident (r_v_r & pred_v & pred_conf), +3 predicted taken (r_v_r & pred_v & pred_taken).
- Global (base G=4*rd_ports_p): G+0 updates (w_v_i & w_yumi_i, "upd"), G+1 mispredicts (upd & br_mispredict_i), G+2 confident mispredicts (upd & br_mispredict_i & br_conf_i), G+3 loop exits (upd & ~br_taken_i).
- Histogram G+4+b: on upd & ~br_taken_i, bin b = min(br_trip_cnt_i >> hist_shift_p, hist_bins_p-1); exactly one bin increments.
- w_v_i without w_yumi_i counts nothing (held request counted once, on acceptance).
- Each counter increments by at most 1 per cycle; all events in a cycle apply in parallel.
- Saturation: counter at all-ones stays all-ones; attempted increment at all-ones sets sat_o (sticky until clear/reset).
- en_i=0: no counter or sat_o update; readout still works.
- clear_i: all counters and sat_o to 0 next cycle; clear wins over same-cycle increments. r_v_r not cleared, so a lookup issued the cycle of clear has its hit counted after clear if en_i=1.
- Readout: rd_v_o <= rd_v_i; rd_data_o <= counter[rd_addr_i] pre-increment value of that cycle (1-cycle latency). Address >= 4*rd_ports_p+4+hist_bins_p returns 0. rd_data_o holds when rd_v_i=0.
- Reset mid-operation: pending lookups dropped; hits arriving the cycle after reset not counted.

Test Plan:
- Reset then read all indices -> every rd_data_o = 0, rd_v_o one cycle after rd_v_i, sat_o=0.
- Port 0 r_v_i 10 cycles, pred_v=1 on 6 following cycles (4 conf, 3 taken); port 1 idle -> idx0=10, idx1=6, idx2=4, idx3=3; idx4..7=0; pred_v with no prior r_v ignored.
- 5 accepted updates, 2 mispredict (1 conf), 3 with br_taken=0 trip counts 2,7,200 (bins 8, shift 0); plus 3 cycles w_v_i=1 w_yumi_i=0 -> G+0=5, G+1=2, G+2=1, G+3=3, bins 2,7 and 7 (clamped) -> bin2=1, bin7=2.
- ctr_width_p=4: 17 lookups on port 0 -> idx0=15, sat_o=1; clear_i -> idx0=0, sat_o=0.
- clear_i same cycle as lookup and update -> all counters 0 after; en_i=0 for 5 lookups -> idx0 unchanged.
- Read idx0 same cycle as its increment -> returns old value; out-of-range addr -> 0.

Source files
------------

// File: rtl/bp_ltb_perf_counters_if.sv
// Snoop/readout bundle between the LTB front end, the CSR bridge and the perf counter block.
// The master drives the observed LTB handshakes and read requests; the slave returns counter data.
interface bp_ltb_perf_counters_if #(
  parameter int ltb_cnt_width_p = 8,
  parameter int rd_ports_p      = 2,
  parameter int ctr_width_p     = 32,
  parameter int hist_bins_p     = 8
);
  localparam int num_ctr_lp    = 4*rd_ports_p + 4 + hist_bins_p;
  localparam int addr_width_lp = (num_ctr_lp > 1) ? $clog2(num_ctr_lp) : 1;

  logic                       en_i;
  logic                       clear_i;
  logic [rd_ports_p-1:0]      r_v_i;
  logic [rd_ports_p-1:0]      pred_v_i;
  logic [rd_ports_p-1:0]      pred_conf_i;
  logic [rd_ports_p-1:0]      pred_taken_i;
  logic                       w_v_i;
  logic                       w_yumi_i;
  logic                       br_mispredict_i;
  logic                       br_conf_i;
  logic                       br_taken_i;
  logic [ltb_cnt_width_p-1:0] br_trip_cnt_i;
  logic                       rd_v_i;
  logic [addr_width_lp-1:0]   rd_addr_i;
  logic                       rd_v_o;
  logic [ctr_width_p-1:0]     rd_data_o;
  logic                       sat_o;

  modport master (
    output en_i, clear_i, r_v_i, pred_v_i, pred_conf_i, pred_taken_i,
    output w_v_i, w_yumi_i, br_mispredict_i, br_conf_i, br_taken_i, br_trip_cnt_i,
    output rd_v_i, rd_addr_i,
    input  rd_v_o, rd_data_o, sat_o
  );

  modport slave (
    input  en_i, clear_i, r_v_i, pred_v_i, pred_conf_i, pred_taken_i,
    input  w_v_i, w_yumi_i, br_mispredict_i, br_conf_i, br_taken_i, br_trip_cnt_i,
    input  rd_v_i, rd_addr_i,
    output rd_v_o, rd_data_o, sat_o
  );
endinterface

// File: rtl/bp_ltb_perf_counters.sv
// Saturating event counters and exit trip-count histogram for the loop termination buffer,
// fed by snooping LTB lookup/update handshakes, with a registered 1-cycle readout port.
module bp_ltb_perf_counters #(
  parameter int vaddr_width_p   = 39,
  parameter int ltb_cnt_width_p = 8,
  parameter int rd_ports_p      = 2,
  parameter int ctr_width_p     = 32,
  parameter int hist_bins_p     = 8,
  parameter int hist_shift_p    = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  bp_ltb_perf_counters_if.slave bus
);
  localparam int num_ctr_lp   = 4*rd_ports_p + 4 + hist_bins_p;
  localparam int glb_lp       = 4*rd_ports_p;
  localparam int hist_base_lp = glb_lp + 4;
  localparam int bin_width_lp = (hist_bins_p > 1) ? $clog2(hist_bins_p) : 1;
  localparam logic [ctr_width_p-1:0]  ctr_one_lp  = ctr_width_p'(1);
  localparam logic [bin_width_lp-1:0] bin_last_lp = bin_width_lp'(hist_bins_p-1);

  logic [rd_ports_p-1:0]      r_v_r;
  logic [ctr_width_p-1:0]     r_ctr [num_ctr_lp];
  logic                       r_sat;
  logic                       r_rd_v;
  logic [ctr_width_p-1:0]     r_rd_data;

  logic [num_ctr_lp-1:0]      w_inc;
  logic [num_ctr_lp-1:0]      w_full;
  logic                       w_upd;
  logic                       w_exit;
  logic                       w_sat_set;
  logic [ltb_cnt_width_p-1:0] w_trip;
  logic [31:0]                w_trip_sh;
  logic [bin_width_lp-1:0]    w_bin;
  logic [ctr_width_p-1:0]     w_rd_val;

  assign w_upd     = bus.w_v_i & bus.w_yumi_i;
  assign w_exit    = w_upd & ~bus.br_taken_i;
  assign w_trip    = bus.br_trip_cnt_i;
  assign w_trip_sh = 32'(w_trip) >> hist_shift_p;
  // Trip counts past the last bin all pile into it so long loops are still visible.
  assign w_bin     = (w_trip_sh >= 32'(hist_bins_p-1)) ? bin_last_lp : bin_width_lp'(w_trip_sh);

  always_comb begin
    w_inc = '0;
    for (int p = 0; p < rd_ports_p; p++) begin
      w_inc[4*p]   = bus.r_v_i[p];
      w_inc[4*p+1] = r_v_r[p] & bus.pred_v_i[p];
      w_inc[4*p+2] = r_v_r[p] & bus.pred_v_i[p] & bus.pred_conf_i[p];
      w_inc[4*p+3] = r_v_r[p] & bus.pred_v_i[p] & bus.pred_taken_i[p];
    end
    w_inc[glb_lp]   = w_upd;
    w_inc[glb_lp+1] = w_upd & bus.br_mispredict_i;
    w_inc[glb_lp+2] = w_upd & bus.br_mispredict_i & bus.br_conf_i;
    w_inc[glb_lp+3] = w_exit;
    w_inc[hist_base_lp + int'(w_bin)] = w_exit;
  end

  always_comb begin
    w_full = '0;
    for (int i = 0; i < num_ctr_lp; i++) begin
      w_full[i] = &r_ctr[i];
    end
  end

  assign w_sat_set = |(w_inc & w_full);

  always_comb begin
    w_rd_val = '0;
    if (32'(bus.rd_addr_i) < 32'(num_ctr_lp)) begin
      w_rd_val = r_ctr[bus.rd_addr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_v_r     <= '0;
      r_sat     <= 1'b0;
      r_rd_v    <= 1'b0;
      r_rd_data <= '0;
      for (int i = 0; i < num_ctr_lp; i++) begin
        r_ctr[i] <= '0;
      end
    end else begin
      // The pending flag tracks the lookup pipeline itself, so it ignores en/clear.
      r_v_r  <= bus.r_v_i;
      r_rd_v <= bus.rd_v_i;
      if (bus.rd_v_i) begin
        r_rd_data <= w_rd_val;
      end
      if (bus.clear_i) begin
        r_sat <= 1'b0;
        for (int i = 0; i < num_ctr_lp; i++) begin
          r_ctr[i] <= '0;
        end
      end else if (bus.en_i) begin
        if (w_sat_set) begin
          r_sat <= 1'b1;
        end
        for (int i = 0; i < num_ctr_lp; i++) begin
          if (w_inc[i] && !w_full[i]) begin
            r_ctr[i] <= r_ctr[i] + ctr_one_lp;
          end
        end
      end
    end
  end

  assign bus.rd_v_o    = r_rd_v;
  assign bus.rd_data_o = r_rd_data;
  assign bus.sat_o     = r_sat;

endmodule

// File: tb/tb_bp_ltb_perf_counters.sv
// Directed bench for bp_ltb_perf_counters: a default 32-bit instance plus a 4-bit instance
// for saturation behaviour, with hand-computed expected counter values.
module tb_bp_ltb_perf_counters;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  bp_ltb_perf_counters_if #(.ltb_cnt_width_p(8), .rd_ports_p(2), .ctr_width_p(32), .hist_bins_p(8)) b0 ();
  bp_ltb_perf_counters_if #(.ltb_cnt_width_p(8), .rd_ports_p(2), .ctr_width_p(4),  .hist_bins_p(8)) b1 ();

  bp_ltb_perf_counters #(.ctr_width_p(32)) u0 (.clk_i(clk), .reset_i(reset), .bus(b0.slave));
  bp_ltb_perf_counters #(.ctr_width_p(4))  u1 (.clk_i(clk), .reset_i(reset), .bus(b1.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero0();
    b0.en_i = 0; b0.clear_i = 0; b0.r_v_i = '0; b0.pred_v_i = '0; b0.pred_conf_i = '0;
    b0.pred_taken_i = '0; b0.w_v_i = 0; b0.w_yumi_i = 0; b0.br_mispredict_i = 0;
    b0.br_conf_i = 0; b0.br_taken_i = 0; b0.br_trip_cnt_i = '0; b0.rd_v_i = 0; b0.rd_addr_i = '0;
  endtask

  task automatic zero1();
    b1.en_i = 0; b1.clear_i = 0; b1.r_v_i = '0; b1.pred_v_i = '0; b1.pred_conf_i = '0;
    b1.pred_taken_i = '0; b1.w_v_i = 0; b1.w_yumi_i = 0; b1.br_mispredict_i = 0;
    b1.br_conf_i = 0; b1.br_taken_i = 0; b1.br_trip_cnt_i = '0; b1.rd_v_i = 0; b1.rd_addr_i = '0;
  endtask

  task automatic rd0(input int a, input logic [31:0] exp, input string tag);
    b0.rd_v_i = 1; b0.rd_addr_i = 5'(a);
    step();
    check({tag, "_v"}, 32'(b0.rd_v_o), 32'd1);
    check(tag, b0.rd_data_o, exp);
    b0.rd_v_i = 0;
  endtask

  task automatic rd1(input int a, input logic [31:0] exp, input string tag);
    b1.rd_v_i = 1; b1.rd_addr_i = 5'(a);
    step();
    check(tag, 32'(b1.rd_data_o), exp);
    b1.rd_v_i = 0;
  endtask

  task automatic upd0(input logic v, input logic y, input logic m, input logic c,
                      input logic t, input logic [7:0] trip);
    b0.w_v_i = v; b0.w_yumi_i = y; b0.br_mispredict_i = m; b0.br_conf_i = c;
    b0.br_taken_i = t; b0.br_trip_cnt_i = trip;
    step();
  endtask

  logic [31:0] glb_exp [12];

  initial begin
    zero0(); zero1();
    reset = 1;
    step(); step();
    check("rst_sat0", 32'(b0.sat_o), 0);
    check("rst_rdv0", 32'(b0.rd_v_o), 0);
    check("rst_rdd0", b0.rd_data_o, 0);
    check("rst_sat1", 32'(b1.sat_o), 0);
    reset = 0;
    for (int a = 0; a < 20; a++) rd0(a, 0, $sformatf("rst_idx%0d", a));
    step();
    check("rdv_drop", 32'(b0.rd_v_o), 0);

    // Lookups on port 0; port 1 sees pred_v with no lookup and must count nothing.
    b0.en_i = 1;
    b0.pred_v_i = 2'b01; b0.pred_conf_i = 2'b01; b0.pred_taken_i = 2'b01;
    step();
    for (int k = 0; k <= 10; k++) begin
      b0.r_v_i[0]        = (k < 10);
      b0.r_v_i[1]        = 1'b0;
      b0.pred_v_i[0]     = (k >= 1 && k <= 6);
      b0.pred_conf_i[0]  = (k >= 1 && k <= 4);
      b0.pred_taken_i[0] = (k >= 1 && k <= 3);
      b0.pred_v_i[1] = 1'b1; b0.pred_conf_i[1] = 1'b1; b0.pred_taken_i[1] = 1'b1;
      step();
    end
    b0.r_v_i = '0; b0.pred_v_i = '0; b0.pred_conf_i = '0; b0.pred_taken_i = '0;
    step();
    rd0(0, 10, "p0_lookup");
    rd0(2, 4,  "p0_conf");
    rd0(3, 3,  "p0_taken");
    for (int a = 4; a < 8; a++) rd0(a, 0, $sformatf("p1_idx%0d", a));
    rd0(1, 6,  "p0_hit");
    step();
    check("hold_data", b0.rd_data_o, 6);
    check("hold_v", 32'(b0.rd_v_o), 0);

    // Updates: 5 accepted plus 3 held (not accepted) requests.
    upd0(1, 1, 1, 1, 1, 8'd0);
    upd0(1, 1, 1, 0, 1, 8'd0);
    upd0(1, 1, 0, 0, 0, 8'd2);
    upd0(1, 1, 0, 0, 0, 8'd7);
    upd0(1, 1, 0, 1, 0, 8'd200);
    upd0(1, 0, 1, 1, 0, 8'd3);
    upd0(1, 0, 1, 1, 0, 8'd3);
    upd0(1, 0, 1, 1, 0, 8'd3);
    upd0(0, 0, 0, 0, 0, 8'd0);
    glb_exp = '{5, 2, 1, 3, 0, 0, 1, 0, 0, 0, 0, 2};
    for (int a = 8; a < 20; a++) rd0(a, glb_exp[a-8], $sformatf("glb_idx%0d", a));

    // Read during increment returns the pre-increment value.
    b0.r_v_i = 2'b01; b0.rd_v_i = 1; b0.rd_addr_i = 5'd0;
    step();
    b0.r_v_i = '0; b0.rd_v_i = 0;
    check("rd_old", b0.rd_data_o, 10);
    rd0(0, 11, "rd_new");
    rd0(20, 0, "oor_20");
    rd0(31, 0, "oor_31");

    // Counting disabled.
    b0.en_i = 0;
    b0.r_v_i = 2'b01;
    repeat (5) step();
    b0.r_v_i = '0;
    step();
    rd0(0, 11, "en_off");
    b0.en_i = 1;

    // Clear wins over same-cycle events; that cycle's lookup still gets its hit counted.
    b0.clear_i = 1; b0.r_v_i = 2'b01;
    upd0(1, 1, 1, 1, 0, 8'd1);
    b0.clear_i = 0; b0.r_v_i = '0;
    b0.w_v_i = 0; b0.w_yumi_i = 0; b0.br_mispredict_i = 0; b0.br_conf_i = 0;
    b0.pred_v_i = 2'b01;
    step();
    b0.pred_v_i = '0;
    for (int a = 0; a < 20; a++) rd0(a, (a == 1) ? 1 : 0, $sformatf("clr_idx%0d", a));
    check("clr_sat0", 32'(b0.sat_o), 0);

    // Saturation on the 4-bit instance.
    b1.en_i = 1; b1.r_v_i = 2'b01;
    repeat (15) step();
    b1.r_v_i = '0;
    step();
    check("sat_before", 32'(b1.sat_o), 0);
    rd1(0, 15, "sat_at15");
    b1.r_v_i = 2'b01;
    repeat (2) step();
    b1.r_v_i = '0;
    step(); step();
    check("sat_set", 32'(b1.sat_o), 1);
    rd1(0, 15, "sat_hold");
    b1.clear_i = 1;
    step();
    b1.clear_i = 0;
    check("sat_clr", 32'(b1.sat_o), 0);
    rd1(0, 0, "sat_clr_idx0");

    // Reset mid-operation drops pending lookups.
    b0.r_v_i = 2'b01;
    step();
    reset = 1; b0.r_v_i = '0;
    step();
    reset = 0; b0.pred_v_i = 2'b01;
    step();
    b0.pred_v_i = '0;
    rd0(0, 0, "rstmid_idx0");
    rd0(1, 0, "rstmid_idx1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
